// File: rtl/unary_stream_decoder_if.sv
// Handshake bundle for the unary stream decoder: unary/sign inputs toward the
// decoder and the valid/ready result stream plus error pulses coming back.
interface unary_stream_decoder_if #(
    parameter int LANES     = 2,
    parameter int BIT_WIDTH = 5
);
    logic                            frame_start;
    logic [LANES-1:0]                unary_in;
    logic [LANES-1:0]                sign_in;
    logic                            out_valid;
    logic                            out_ready;
    logic [LANES-1:0][BIT_WIDTH-1:0] out_data;
    logic [LANES-1:0]                out_sat;
    logic                            frame_err;
    logic                            drop_err;

    modport master (
        output frame_start, unary_in, sign_in, out_ready,
        input  out_valid, out_data, out_sat, frame_err, drop_err
    );

    modport slave (
        input  frame_start, unary_in, sign_in, out_ready,
        output out_valid, out_data, out_sat, frame_err, drop_err
    );
endinterface

// File: rtl/unary_stream_decoder.sv
// Counts ones per lane over a fixed window, converts the count to a signed word
// and queues the per-window result in a 2-entry registered output FIFO.
module unary_stream_decoder #(
    parameter int BIT_WIDTH = 5,
    parameter int SIZE      = BIT_WIDTH - 1,
    parameter int LANES     = 2,
    parameter int WINDOW    = (1 << SIZE) + 2,
    parameter int CNT_W     = $clog2(WINDOW + 1)
) (
    input logic                   clk,
    input logic                   reset,
    unary_stream_decoder_if.slave bus
);
    localparam int MAX_MAG = (1 << SIZE) - 1;

    typedef enum logic {IDLE, COLLECT} state_t;
    typedef logic [LANES-1:0][BIT_WIDTH-1:0] words_t;

    state_t                      r_state;
    logic [CNT_W-1:0]            r_pos;
    logic [LANES-1:0][CNT_W-1:0] r_cnt;
    logic [LANES-1:0]            r_seen_zero;
    logic [LANES-1:0]            r_shape_err;
    logic [LANES-1:0]            r_sign;
    logic                        r_frame_err;

    words_t                      r_head_data, r_tail_data;
    logic [LANES-1:0]            r_head_sat, r_tail_sat;
    logic                        r_head_vld, r_tail_vld;
    logic                        r_drop_err;

    logic [LANES-1:0][CNT_W-1:0] w_cnt_final;
    logic [LANES-1:0]            w_shape_final;
    logic [LANES-1:0]            w_sat;
    words_t                      w_words;
    logic                        w_last;
    logic                        w_pop;

    function automatic logic [SIZE-1:0] sat_mag(input logic [CNT_W-1:0] cnt);
        if (cnt > CNT_W'(MAX_MAG)) begin
            return SIZE'(MAX_MAG);
        end else begin
            return cnt[SIZE-1:0];
        end
    endfunction

    function automatic logic signed [BIT_WIDTH-1:0] to_word(input logic [SIZE-1:0] mag,
                                                            input logic neg);
        logic signed [BIT_WIDTH-1:0] mag_s;
        mag_s = BIT_WIDTH'(mag);
        return neg ? -mag_s : mag_s;
    endfunction

    // The last window cycle's bit is folded in combinationally so the push
    // happens on the edge that ends the window.
    assign w_last = (r_state == COLLECT) && (r_pos == CNT_W'(WINDOW - 1));
    assign w_pop  = r_head_vld && bus.out_ready;

    always_comb begin
        w_cnt_final   = '0;
        w_shape_final = '0;
        w_sat         = '0;
        w_words       = '0;
        for (int l = 0; l < LANES; l++) begin
            w_cnt_final[l]   = r_cnt[l] + CNT_W'(bus.unary_in[l]);
            w_shape_final[l] = r_shape_err[l] | (r_seen_zero[l] & bus.unary_in[l]);
            w_sat[l]         = (w_cnt_final[l] > CNT_W'(MAX_MAG)) | w_shape_final[l];
            w_words[l]       = to_word(sat_mag(w_cnt_final[l]), r_sign[l]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_pos       <= '0;
            r_cnt       <= '0;
            r_seen_zero <= '0;
            r_shape_err <= '0;
            r_sign      <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (bus.frame_start) begin
                // A start before the last cycle abandons the partial window.
                r_frame_err <= (r_state == COLLECT) && !w_last;
                r_state     <= COLLECT;
                r_pos       <= CNT_W'(1);
                r_shape_err <= '0;
                r_seen_zero <= ~bus.unary_in;
                r_sign      <= bus.sign_in;
                for (int l = 0; l < LANES; l++) begin
                    r_cnt[l] <= CNT_W'(bus.unary_in[l]);
                end
            end else if (r_state == COLLECT) begin
                if (w_last) begin
                    r_state <= IDLE;
                end else begin
                    r_pos       <= r_pos + CNT_W'(1);
                    r_cnt       <= w_cnt_final;
                    r_shape_err <= w_shape_final;
                    r_seen_zero <= r_seen_zero | ~bus.unary_in;
                end
            end
        end
    end

    // Head register drives the outputs directly; tail is the second slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head_data <= '0;
            r_head_sat  <= '0;
            r_head_vld  <= 1'b0;
            r_tail_data <= '0;
            r_tail_sat  <= '0;
            r_tail_vld  <= 1'b0;
            r_drop_err  <= 1'b0;
        end else begin
            r_drop_err <= w_last && r_tail_vld && !w_pop;
            if (w_pop) begin
                if (r_tail_vld) begin
                    r_head_data <= r_tail_data;
                    r_head_sat  <= r_tail_sat;
                    if (w_last) begin
                        r_tail_data <= w_words;
                        r_tail_sat  <= w_sat;
                    end else begin
                        r_tail_vld <= 1'b0;
                    end
                end else if (w_last) begin
                    r_head_data <= w_words;
                    r_head_sat  <= w_sat;
                end else begin
                    r_head_vld <= 1'b0;
                end
            end else if (w_last) begin
                if (!r_head_vld) begin
                    r_head_data <= w_words;
                    r_head_sat  <= w_sat;
                    r_head_vld  <= 1'b1;
                end else if (!r_tail_vld) begin
                    r_tail_data <= w_words;
                    r_tail_sat  <= w_sat;
                    r_tail_vld  <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = r_head_vld;
    assign bus.out_data  = r_head_data;
    assign bus.out_sat   = r_head_sat;
    assign bus.frame_err = r_frame_err;
    assign bus.drop_err  = r_drop_err;
endmodule

// File: tb/tb_unary_stream_decoder.sv
// Directed and random windows against a count-the-ones reference model with a
// queue standing in for the output FIFO.
module tb_unary_stream_decoder;
  localparam int BW     = 5;
  localparam int LANES  = 2;
  localparam int WINDOW = 18;
  localparam int MAXM   = 15;

  typedef struct {
    logic [LANES*BW-1:0] data;
    logic [LANES-1:0]    sat;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  ent_t mq[$];
  logic exp_drop = 1'b0;
  logic exp_ferr = 1'b0;
  logic open_win = 1'b0;
  logic rand_ready = 1'b0;
  int drop_cnt = 0;
  int ferr_cnt = 0;
  logic [LANES-1:0] stim [WINDOW];

  unary_stream_decoder_if #(.LANES(LANES), .BIT_WIDTH(BW)) bus ();

  unary_stream_decoder #(.BIT_WIDTH(BW), .LANES(LANES)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("out_data", 32'(bus.out_data), 32'(mq[0].data));
        chk("out_sat", 32'(bus.out_sat), 32'(mq[0].sat));
        if (bus.out_ready) void'(mq.pop_front());
      end
      chk("drop_err", 32'(bus.drop_err), 32'(exp_drop));
      chk("frame_err", 32'(bus.frame_err), 32'(exp_ferr));
      if (bus.drop_err) drop_cnt++;
      if (bus.frame_err) ferr_cnt++;
      exp_drop = 1'b0;
      exp_ferr = 1'b0;
    end
  end

  task automatic drive_cycle(input logic fs, input logic [LANES-1:0] u, input logic [LANES-1:0] s);
    bus.frame_start = fs;
    bus.unary_in    = u;
    bus.sign_in     = s;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic fill_therm(input int k0, input int k1);
    for (int i = 0; i < WINDOW; i++) stim[i] = {logic'(i < k1), logic'(i < k0)};
  endtask

  // Sends n cycles of stim; a full window is scored, a short one is abandoned
  // by whatever window the caller starts next.
  task automatic run_window(input logic [LANES-1:0] sg, input int n);
    ent_t e;
    int ones, mag, w;
    bit seen0, shape;
    for (int i = 0; i < n; i++) begin
      drive_cycle(i == 0, stim[i], (i == 0) ? sg : 2'($urandom));
      if (i == 0 && open_win) exp_ferr = 1'b1;
    end
    open_win = (n < WINDOW);
    if (n == WINDOW) begin
      e.data = '0;
      e.sat  = '0;
      for (int l = 0; l < LANES; l++) begin
        ones = 0; seen0 = 0; shape = 0;
        for (int i = 0; i < WINDOW; i++) begin
          if (stim[i][l]) begin
            ones++;
            if (seen0) shape = 1;
          end else begin
            seen0 = 1;
          end
        end
        mag = (ones > MAXM) ? MAXM : ones;
        w = sg[l] ? -mag : mag;
        e.data[l*BW +: BW] = w[BW-1:0];
        e.sat[l] = (ones > MAXM) || shape;
      end
      if (mq.size() >= 2) exp_drop = 1'b1;
      else mq.push_back(e);
    end
  endtask

  task automatic check_head(input string tag, input logic [LANES*BW-1:0] d, input logic [LANES-1:0] s);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
    chk({tag, "_sat"}, 32'(bus.out_sat), 32'(s));
    @(posedge clk);
    #1;
  endtask

  task automatic expect_empty(input string tag);
    @(negedge clk);
    chk(tag, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0, f0, n, gap, mode;
    int kl [LANES];
    bus.frame_start = 1'b0;
    bus.unary_in    = '0;
    bus.sign_in     = '0;
    bus.out_ready   = 1'b1;

    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_sat", 32'(bus.out_sat), 32'd0);
    chk("rst_ferr", 32'(bus.frame_err), 32'd0);
    chk("rst_drop", 32'(bus.drop_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // basic decode: lane0 +5, lane1 -7
    fill_therm(5, 7);
    run_window(2'b10, WINDOW);
    check_head("t1", 10'b11001_00101, 2'b00);
    expect_empty("t1_popped");

    // extremes: zero with sign, full scale, over-range
    fill_therm(0, 15);
    run_window(2'b01, WINDOW);
    check_head("t2a", 10'b01111_00000, 2'b00);
    fill_therm(0, 17);
    run_window(2'b00, WINDOW);
    check_head("t2b", 10'b01111_00000, 2'b10);

    // non-thermometer shape on lane0
    for (int i = 0; i < WINDOW; i++) stim[i] = '0;
    stim[0] = 2'b01; stim[1] = 2'b01; stim[3] = 2'b01;
    run_window(2'b00, WINDOW);
    check_head("t3", 10'b00000_00011, 2'b01);

    // back-pressure with three back-to-back windows
    bus.out_ready = 1'b0;
    d0 = drop_cnt;
    f0 = ferr_cnt;
    for (int v = 1; v <= 3; v++) begin
      fill_therm(v, 0);
      run_window(2'b00, WINDOW);
    end
    check_head("t4_stall", 10'd1, 2'b00);
    chk("t4_drops", 32'(drop_cnt - d0), 32'd1);
    chk("t4_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    bus.out_ready = 1'b1;
    check_head("t4_first", 10'd1, 2'b00);
    check_head("t4_second", 10'd2, 2'b00);
    expect_empty("t4_drained");

    // early frame_start at pos 9
    f0 = ferr_cnt;
    fill_therm(4, 4);
    run_window(2'b00, 9);
    fill_therm(6, 2);
    run_window(2'b01, WINDOW);
    check_head("t5", 10'b00010_11010, 2'b00);
    chk("t5_ferr", 32'(ferr_cnt - f0), 32'd1);
    expect_empty("t5_single");

    // reset mid-window with one entry pending
    bus.out_ready = 1'b0;
    fill_therm(3, 3);
    run_window(2'b00, WINDOW);
    fill_therm(5, 5);
    run_window(2'b00, 6);
    reset = 1'b1;
    #1;
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_data", 32'(bus.out_data), 32'd0);
    chk("t6_sat", 32'(bus.out_sat), 32'd0);
    chk("t6_ferr", 32'(bus.frame_err), 32'd0);
    chk("t6_drop", 32'(bus.drop_err), 32'd0);
    mq.delete();
    open_win = 1'b0;
    exp_drop = 1'b0;
    exp_ferr = 1'b0;
    bus.frame_start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    fill_therm(9, 1);
    run_window(2'b11, WINDOW);
    check_head("t6_after", 10'b11111_10111, 2'b00);

    // random windows, random gaps, random back-pressure
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      mode = $urandom_range(0, 2);
      for (int l = 0; l < LANES; l++) kl[l] = $urandom_range(0, WINDOW);
      for (int i = 0; i < WINDOW; i++) begin
        for (int l = 0; l < LANES; l++) begin
          case (mode)
            0: stim[i][l] = 1'($urandom_range(0, 1));
            1: stim[i][l] = (i < kl[l]);
            default: stim[i][l] = ($urandom_range(0, 7) != 0);
          endcase
        end
      end
      n = (k != 59 && $urandom_range(0, 5) == 0) ? $urandom_range(1, WINDOW - 2) : WINDOW;
      gap = open_win ? 0 : $urandom_range(0, 2);
      repeat (gap) drive_cycle(1'b0, 2'($urandom), 2'($urandom));
      run_window(2'($urandom), n);
    end
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) drive_cycle(1'b0, '0, '0);
    expect_empty("rand_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
